// File: rtl/pipelined_multiplier_n.sv
// Pipelined shift-and-add array multiplier with valid/ready flow control.
// An input register is followed by STAGES adder stages, each summing
// ROWS_PER_STAGE partial-product rows. The whole pipeline stalls as one
// unit whenever a result is held at the output and not consumed.
// Optional feature macro: MULT_SIGNED_EN enables per-operation two's-complement
// mode. Without it signed_in is accepted but ignored and only unsigned
// products are built.
module pipelined_multiplier_n #(
  parameter int unsigned WIDTH_A        = 16,
  parameter int unsigned WIDTH_B        = 16,
  parameter int unsigned ROWS_PER_STAGE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  input  logic                       signed_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0] y,
  output logic                       busy
);

  localparam int unsigned W      = WIDTH_A + WIDTH_B;
  localparam int unsigned STAGES = (WIDTH_A + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;

  // Index 0 is the input register; index k+1 is the output of adder stage k.
  logic [STAGES:0]                   vld;
  logic [STAGES:1][W-1:0]            sum_q;
  // Operands only need to travel as far as the last adder stage's input.
  logic [STAGES-1:0][WIDTH_A-1:0]    a_q;
  logic [STAGES-1:0][WIDTH_B-1:0]    b_q;
  logic [STAGES-1:0][W-1:0]          sum_nxt;
  logic                              enable;

`ifdef MULT_SIGNED_EN
  logic [STAGES-1:0]                 mode_q;
`else
  logic                              unused_signed_in;
  assign unused_signed_in = signed_in;
`endif

  // Global stall: freeze everything while a result waits at the output.
  assign enable    = !(out_valid && !out_ready);
  assign in_ready  = enable;
  assign out_valid = vld[STAGES];
  assign y         = sum_q[STAGES];
  assign busy      = |vld;

  // Per-stage partial-product accumulation.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W-1:0] base;
    logic [W-1:0] b_ext;
    logic [W-1:0] acc_c;

    if (k == 0) begin : g_base
      assign base = '0;
    end else begin : g_base
      assign base = sum_q[k];
    end

`ifdef MULT_SIGNED_EN
    assign b_ext = mode_q[k] ? {{WIDTH_A{b_q[k][WIDTH_B-1]}}, b_q[k]}
                             : {{WIDTH_A{1'b0}}, b_q[k]};
`else
    assign b_ext = {{WIDTH_A{1'b0}}, b_q[k]};
`endif

    // Add (or, for the sign row in signed mode, subtract) this stage's rows.
    always_comb begin
      logic [W-1:0] row;
      int unsigned  idx;
      acc_c = base;
      row   = '0;
      idx   = 0;
      for (int unsigned r = 0; r < ROWS_PER_STAGE; r++) begin
        idx = k * ROWS_PER_STAGE + r;
        if (idx < WIDTH_A) begin
          row = ((a_q[k] & (WIDTH_A'(1) << idx)) != '0) ? (b_ext << idx) : '0;
`ifdef MULT_SIGNED_EN
          if (mode_q[k] && (idx == WIDTH_A - 1)) begin
            acc_c = acc_c - row;
          end else begin
            acc_c = acc_c + row;
          end
`else
          acc_c = acc_c + row;
`endif
        end
      end
    end

    assign sum_nxt[k] = acc_c;
  end

  // Input capture and pipeline advance; invalid slots carry a zero sum so y is 0 when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld   <= '0;
      sum_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
`ifdef MULT_SIGNED_EN
      mode_q <= '0;
`endif
    end else if (enable) begin
      vld[0] <= in_valid;
      a_q[0] <= a;
      b_q[0] <= b;
`ifdef MULT_SIGNED_EN
      mode_q[0] <= signed_in;
`endif
      for (int unsigned k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
`ifdef MULT_SIGNED_EN
        mode_q[k] <= mode_q[k-1];
`endif
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        vld[k+1]   <= vld[k];
        sum_q[k+1] <= vld[k] ? sum_nxt[k] : '0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_multiplier_n.sv
// Bench for pipelined_multiplier_n: an 8x8 one-row-per-stage instance and an
// 8x8 three-rows-per-stage instance, checked against an arithmetic product model.
// Signed expectations follow MULT_SIGNED_EN.
module tb_pipelined_multiplier_n;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, signed_in, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] y;
  logic        in_valid3, in_ready3, signed_in3, out_valid3, out_ready3, busy3;
  logic [7:0]  a3, b3;
  logic [15:0] y3;

  int errors;
  int checks;

  pipelined_multiplier_n #(.WIDTH_A(8), .WIDTH_B(8), .ROWS_PER_STAGE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_in(signed_in), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .busy(busy)
  );

  pipelined_multiplier_n #(.WIDTH_A(8), .WIDTH_B(8), .ROWS_PER_STAGE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .signed_in(signed_in3), .out_valid(out_valid3),
    .out_ready(out_ready3), .y(y3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product truncated to 16 bits, from plain integer arithmetic.
  function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] z, input logic s);
    logic   sm;
    longint xv, zv, p;
    sm = s;
`ifndef MULT_SIGNED_EN
    sm = 1'b0;
`endif
    xv = sm ? longint'($signed(x)) : longint'(x);
    zv = sm ? longint'($signed(z)) : longint'(z);
    p  = xv * zv;
    return p[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (y !== 16'h0) begin errors++; $display("FAIL reset_y got=%h want=0000", y); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid3 got=%b want=0", out_valid3); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    int first;
    logic [15:0] yv;
    first = 0;
    yv = '0;
    out_ready = 1'b1;
    a = 8'd13; b = 8'd11; signed_in = 1'b0; in_valid = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      step();
      if (e == 1) in_valid = 1'b0;
      if (e == 4) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL latency_busy got=%b want=1", busy); end
        checks++; if (y !== 16'h0) begin errors++; $display("FAIL idle_y_zero got=%h want=0000", y); end
      end
      if (out_valid && first == 0) begin first = e; yv = y; end
    end
    checks++; if (first != 9) begin errors++; $display("FAIL latency_edges got=%0d want=9", first); end
    checks++; if (yv !== 16'h008F) begin errors++; $display("FAIL latency_y got=%h want=008f", yv); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drained_busy got=%b want=0", busy); end
  endtask

  task automatic test_directed();
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic        ts [3];
    logic [15:0] te [3];
    ta[0] = 8'hFF; tb[0] = 8'hFF; ts[0] = 1'b0; te[0] = 16'hFE01;
    ta[1] = 8'hFF; tb[1] = 8'hFF; ts[1] = 1'b1;
    ta[2] = 8'h80; tb[2] = 8'h7F; ts[2] = 1'b1;
`ifdef MULT_SIGNED_EN
    te[1] = 16'h0001; te[2] = 16'hC080;
`else
    te[1] = 16'hFE01; te[2] = 16'h3F80;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit seen;
      seen = 1'b0;
      a = ta[i]; b = tb[i]; signed_in = ts[i]; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        if (out_valid) begin
          seen = 1'b1;
          checks++;
          if (y !== te[i]) begin errors++; $display("FAIL directed_%0d got=%h want=%h", i, y, te[i]); end
        end
        step();
      end
      if (!seen) begin checks++; errors++; $display("FAIL directed_%0d_timeout got=none want=%h", i, te[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q [$];
    int sent, got, first_cyc, last_cyc;
    sent = 0; got = 0; first_cyc = -1; last_cyc = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_extra got=%h want=none", y); end
        else begin
          logic [15:0] e;
          e = q.pop_front();
          if (y !== e) begin errors++; $display("FAIL b2b_result_%0d got=%h want=%h", got, y, e); end
        end
        got++;
      end
      if (sent < 20) begin
        a = 8'($urandom); b = 8'($urandom); signed_in = 1'($urandom); in_valid = 1'b1;
        if (in_ready) begin q.push_back(model(a, b, signed_in)); sent++; end
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (got != 20) begin errors++; $display("FAIL b2b_count got=%0d want=20", got); end
    checks++; if (last_cyc - first_cyc != 19) begin errors++; $display("FAIL b2b_consecutive got=%0d want=19", last_cyc - first_cyc); end
  endtask

  task automatic test_backpressure();
    logic [15:0] q [$];
    logic [15:0] held;
    int sent, got, phase, stall;
    sent = 0; got = 0; phase = 0; stall = 0; held = '0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 16; cyc++) begin
      if (phase == 0 && out_valid) begin phase = 1; stall = 5; held = y; end
      out_ready = (phase == 1) ? 1'b0 : 1'b1;
      #1;
      if (phase == 1) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
        checks++; if (y !== held) begin errors++; $display("FAIL stall_y_stable got=%h want=%h", y, held); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid got=%b want=1", out_valid); end
        stall--;
        if (stall == 0) phase = 2;
      end else if (out_valid) begin
        logic [15:0] e;
        checks++;
        e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        if (y !== e) begin errors++; $display("FAIL bp_result_%0d got=%h want=%h", got, y, e); end
        got++;
      end
      if (sent < 16) begin
        a = 8'($urandom); b = 8'($urandom); signed_in = 1'($urandom); in_valid = 1'b1;
        if (in_ready) begin q.push_back(model(a, b, signed_in)); sent++; end
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 16) begin errors++; $display("FAIL bp_count got=%0d want=16", got); end
    checks++; if (phase != 2) begin errors++; $display("FAIL bp_stall_seen got=%0d want=2", phase); end
  endtask

  task automatic test_random_flow();
    logic [15:0] q [$];
    int sent, got;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 800 && got < 30; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (out_valid && out_ready) begin
        logic [15:0] e;
        checks++;
        e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        if (y !== e) begin errors++; $display("FAIL flow_result_%0d got=%h want=%h", got, y, e); end
        got++;
      end
      if (sent < 30 && $urandom_range(0, 9) < 7) begin
        a = 8'($urandom); b = 8'($urandom); signed_in = 1'($urandom); in_valid = 1'b1;
        if (in_ready) begin q.push_back(model(a, b, signed_in)); sent++; end
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got != 30 || q.size() != 0) begin errors++; $display("FAIL flow_count got=%0d left=%0d want=30/0", got, q.size()); end
  endtask

  task automatic test_reset_mid();
    int stale;
    stale = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom); signed_in = 1'b0; in_valid = 1'b1;
      step();
    end
    a = 8'd7; b = 8'd9; in_valid = 1'b1; rst_n = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
    checks++; if (y !== 16'h0) begin errors++; $display("FAIL rst_mid_y got=%h want=0000", y); end
    rst_n = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rst_mid_stale got=%0d want=0", stale); end
  endtask

  task automatic test_rows3();
    logic [15:0] q [$];
    int first, sent, got;
    logic [15:0] yv;
    first = 0; yv = '0;
    out_ready3 = 1'b1;
    a3 = 8'd200; b3 = 8'd3; signed_in3 = 1'b0; in_valid3 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 1) in_valid3 = 1'b0;
      if (out_valid3 && first == 0) begin first = e; yv = y3; end
    end
    checks++; if (first != 4) begin errors++; $display("FAIL rows3_latency got=%0d want=4", first); end
    checks++; if (yv !== 16'h0258) begin errors++; $display("FAIL rows3_y got=%h want=0258", yv); end
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      if (out_valid3) begin
        logic [15:0] e;
        checks++;
        e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        if (y3 !== e) begin errors++; $display("FAIL rows3_result_%0d got=%h want=%h", got, y3, e); end
        got++;
      end
      if (sent < 10) begin
        a3 = 8'($urandom); b3 = 8'($urandom); signed_in3 = 1'($urandom); in_valid3 = 1'b1;
        if (in_ready3) begin q.push_back(model(a3, b3, signed_in3)); sent++; end
      end else begin
        in_valid3 = 1'b0;
      end
      step();
    end
    in_valid3 = 1'b0;
    checks++; if (got != 10) begin errors++; $display("FAIL rows3_count got=%0d want=10", got); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; signed_in = 1'b0; out_ready = 1'b1;
    in_valid3 = 1'b0; a3 = '0; b3 = '0; signed_in3 = 1'b0; out_ready3 = 1'b1;
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random_flow();
    test_reset_mid();
    test_rows3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_multiplier_n.md
PIPELINED_MULTIPLIER_N -- requirements
Module: pipelined_multiplier_n

Interface
REQ-001 SHALL have parameter WIDTH_A, default 16: width of operand a (row count of the array).
REQ-002 SHALL have parameter WIDTH_B, default 16: width of operand b.
REQ-003 SHALL have parameter ROWS_PER_STAGE, default 1: partial-product rows accumulated per pipeline stage; STAGES = ceil(WIDTH_A/ROWS_PER_STAGE).
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  operands a, b, signed_in are valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-008 SHALL have port a  input  WIDTH_A  multiplier operand.
REQ-009 SHALL have port b  input  WIDTH_B  multiplicand operand.
REQ-010 SHALL have port signed_in  input  1  per-operation mode: 1 = two's-complement, 0 = unsigned.
REQ-011 SHALL have port out_valid  output  1  y holds a completed product.
REQ-012 SHALL have port out_ready  input  1  downstream consumes y this cycle.
REQ-013 SHALL have port y  output  WIDTH_A+WIDTH_B  product.
REQ-014 SHALL have port busy  output  1  at least one valid operation in flight or held at output.

Function
REQ-015 SHALL advance the whole pipeline on an edge only when enable = !(out_valid && !out_ready); in_ready = enable, combinationally.
REQ-016 SHALL accept an operation on an edge where in_valid && in_ready; a, b, signed_in captured into the input register with a valid bit.
REQ-017 SHALL carry a, b, mode and valid bit alongside the partial sum through every stage.
REQ-018 SHALL, in stage k (0..STAGES-1), add rows i = k*ROWS_PER_STAGE .. min((k+1)*ROWS_PER_STAGE, WIDTH_A)-1, row i = (a[i] ? b_ext << i : 0), to the partial sum of stage k-1 (stage 0 starts from 0).
REQ-019 SHALL use b_ext = b zero-extended to WIDTH_A+WIDTH_B when mode = 0, sign-extended when mode = 1.
REQ-020 SHALL, when mode = 1, subtract (not add) row WIDTH_A-1, giving the exact two's-complement product.
REQ-021 SHALL compute all sums modulo 2^(WIDTH_A+WIDTH_B); y equals the exact product in that width for every input in both modes.
REQ-022 SHALL have latency L = 1 + STAGES enabled edges from acceptance to out_valid = 1 (WIDTH_A=8, ROWS_PER_STAGE=1: L = 9).
REQ-023 SHALL sustain throughput of one operation per cycle while out_ready = 1; bubbles (in_valid = 0) propagate as invalid slots.
REQ-024 SHALL hold y, out_valid and all stage contents unchanged while out_valid && !out_ready.
REQ-025 SHALL preserve operation order; no operation dropped or duplicated under any in_valid/out_ready pattern.
REQ-026 SHALL drive y = 0 whenever out_valid = 0.
REQ-027 SHALL assert busy = OR of all stage valid bits including the output stage.

Reset
REQ-028 SHALL, on an edge with rst_n = 0, clear all valid bits, partial sums and captured operands to 0, whatever the enable state.
REQ-029 SHALL, after reset, drive out_valid = 0, y = 0, busy = 0, in_ready = 1.
REQ-030 SHALL discard all in-flight operations on reset mid-operation; an operand offered in the reset cycle is not accepted.

Configuration
REQ-031 SHALL, with macro MULT_SIGNED_EN defined, implement signed mode per REQ-019/REQ-020.
REQ-032 SHALL, with MULT_SIGNED_EN undefined, keep port signed_in but ignore it (mode forced 0), compute unsigned only, and build no mode register or subtract path.

Verification
REQ-033 SHALL cover: WIDTH_A=WIDTH_B=8, ROWS_PER_STAGE=1, a=13, b=11, unsigned -> y=0x008F with out_valid exactly 9 edges after acceptance.
REQ-034 SHALL cover: a=255, b=255 unsigned -> 0xFE01; a=0xFF, b=0xFF signed -> 0x0001; a=0x80, b=0x7F signed -> 0xC080 (MULT_SIGNED_EN defined).
REQ-035 SHALL cover: 20 back-to-back random operations, out_ready=1 -> 20 results in order on consecutive cycles, each matching a reference model.
REQ-036 SHALL cover: out_ready held 0 for 5 cycles with full pipeline -> in_ready=0, y stable; on release, results resume in order, none lost.
REQ-037 SHALL cover: rst_n=0 for one edge with 4 operations in flight -> out_valid=0, busy=0 next cycle, no stale result ever emerges.
REQ-038 SHALL cover: WIDTH_A=8, ROWS_PER_STAGE=3 (STAGES=3), a=200, b=3 unsigned -> y=0x0258 after 4 edges.
